// File: rtl/word_pkg.sv
// rtl/word_pkg.sv - shared types and word list for the round controller
package word_pkg;

    localparam int WORD_LEN  = 8;
    localparam int CHAR_W    = 8;
    localparam int NUM_WORDS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_LOAD,
        ST_PLAY,
        ST_DONE
    } state_t;

    localparam logic [3:0] WORD_LEN_TAB [NUM_WORDS] = '{
        4'd5, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6
    };

    // Character 0 sits in the least significant byte; unused tail bytes are 0x00.
    localparam logic [WORD_LEN*CHAR_W-1:0] WORD_LIST [NUM_WORDS] = '{
        64'h0000_0045_4C50_5041,  // APPLE
        64'h0000_0045_5355_4F48,  // HOUSE
        64'h0000_5241_5449_5547,  // GUITAR
        64'h0000_5445_4B43_4F52,  // ROCKET
        64'h0000_5245_574F_4C46,  // FLOWER
        64'h0000_414E_414E_4142,  // BANANA
        64'h0000_454C_5453_4143,  // CASTLE
        64'h0000_4C49_434E_4550   // PENCIL
    };

endpackage

// File: rtl/word_round_ctrl_if.sv
// rtl/word_round_ctrl_if.sv - game-side control inputs and display/state outputs
interface word_round_ctrl_if;
    import word_pkg::*;

    logic                       new_game;
    logic [2:0]                 word_index;
    logic                       guess_correct;
    logic [WORD_LEN*CHAR_W-1:0] word_chars;
    logic [3:0]                 word_len;
    logic [WORD_LEN-1:0]        hint_mask;
    logic [6:0]                 secs_left;
    logic                       round_active;
    logic                       round_over;
    logic                       win;

    modport master (
        output new_game, word_index, guess_correct,
        input  word_chars, word_len, hint_mask, secs_left, round_active, round_over, win
    );

    modport slave (
        input  new_game, word_index, guess_correct,
        output word_chars, word_len, hint_mask, secs_left, round_active, round_over, win
    );
endinterface

// File: rtl/word_rom.sv
// rtl/word_rom.sv - word list ROM, address {word, char}, one-cycle read latency
module word_rom
    import word_pkg::*;
(
    input  logic              clk,
    input  logic [5:0]        addr,
    output logic [CHAR_W-1:0] data
);
    logic [WORD_LEN*CHAR_W-1:0] word;

    assign word = WORD_LIST[addr[5:3]];

    always_ff @(posedge clk) begin
        data <= word[addr[2:0]*CHAR_W +: CHAR_W];
    end
endmodule

// File: rtl/word_round_ctrl.sv
// rtl/word_round_ctrl.sv - latches a word, loads it from ROM, runs the timed guessing round
module word_round_ctrl
    import word_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int ROUND_SECS    = 60,
    parameter int HINT_INTERVAL = 15
) (
    input  logic             clk,
    input  logic             rst,
    word_round_ctrl_if.slave bus
);
    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HINT_W  = (HINT_INTERVAL > 1) ? $clog2(HINT_INTERVAL) : 1;

    state_t                     state, state_nxt;
    logic [2:0]                 idx_q;
    logic [3:0]                 cnt;
    logic [PRESC_W-1:0]         presc;
    logic [HINT_W-1:0]          hint_cnt;
    logic [3:0]                 reveal_cnt;
    logic [WORD_LEN*CHAR_W-1:0] chars_q;
    logic [3:0]                 len_q;
    logic [WORD_LEN-1:0]        mask_q;
    logic [6:0]                 secs_q;
    logic                       win_q;
    logic [CHAR_W-1:0]          rom_data;
    logic                       wrap, time_up, finish;
    logic [2:0]                 slot;
    logic [WORD_LEN-1:0]        full_mask;

    word_rom u_rom (
        .clk  (clk),
        .addr ({idx_q, cnt[2:0]}),
        .data (rom_data)
    );

    assign wrap      = (state == ST_PLAY) && (presc == PRESC_W'(TICKS_PER_SEC - 1));
    assign time_up   = wrap && (secs_q == 7'd1);
    assign finish    = (state == ST_PLAY) && (bus.guess_correct || time_up);
    // ROM data lags the address by one cycle, so it lands one slot behind cnt.
    assign slot      = cnt[2:0] - 3'd1;
    assign full_mask = WORD_LEN'((32'd1 << len_q) - 32'd1);

    always_comb begin
        state_nxt = state;
        if (bus.new_game) begin
            state_nxt = ST_LATCH;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_LATCH: state_nxt = ST_LOAD;
                ST_LOAD:  if (cnt == 4'(WORD_LEN)) state_nxt = ST_PLAY;
                ST_PLAY:  if (finish) state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_DONE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx_q      <= '0;
            cnt        <= '0;
            presc      <= '0;
            hint_cnt   <= '0;
            reveal_cnt <= '0;
            chars_q    <= '0;
            len_q      <= '0;
            mask_q     <= '0;
            secs_q     <= '0;
            win_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bus.new_game) begin
                win_q <= 1'b0;
            end else begin
                case (state)
                    ST_LATCH: begin
                        idx_q   <= bus.word_index;
                        chars_q <= '0;
                        mask_q  <= '0;
                        len_q   <= WORD_LEN_TAB[bus.word_index];
                        cnt     <= '0;
                    end
                    ST_LOAD: begin
                        cnt <= cnt + 4'd1;
                        if (cnt != 4'd0) chars_q[slot*CHAR_W +: CHAR_W] <= rom_data;
                        if (cnt == 4'(WORD_LEN)) begin
                            secs_q     <= 7'(ROUND_SECS);
                            presc      <= '0;
                            hint_cnt   <= '0;
                            reveal_cnt <= '0;
                        end
                    end
                    ST_PLAY: begin
                        presc <= wrap ? '0 : presc + 1'b1;
                        if (wrap) begin
                            secs_q <= secs_q - 7'd1;
                            if (hint_cnt == HINT_W'(HINT_INTERVAL - 1)) begin
                                hint_cnt <= '0;
                                // Letters are revealed in order, so reveal_cnt is the lowest hidden index.
                                if (reveal_cnt < len_q - 4'd1) begin
                                    mask_q[reveal_cnt[2:0]] <= 1'b1;
                                    reveal_cnt              <= reveal_cnt + 4'd1;
                                end
                            end else begin
                                hint_cnt <= hint_cnt + 1'b1;
                            end
                        end
                        if (finish) begin
                            win_q  <= bus.guess_correct;
                            mask_q <= full_mask;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.word_chars   = chars_q;
    assign bus.word_len     = len_q;
    assign bus.hint_mask    = mask_q;
    assign bus.secs_left    = secs_q;
    assign bus.round_active = (state == ST_PLAY);
    assign bus.round_over   = (state == ST_DONE);
    assign bus.win          = win_q;
endmodule
